// File: rtl/mem_system_ctrl_2way.sv
// Controller for a 2-way set-associative cache backed by a pipelined,
// banked main memory. A request is looked up in both ways at once; a miss
// optionally writes the victim line back, refills it word by word from
// memory and finishes with one compare-mode retry access.
module mem_system_ctrl_2way #(
  parameter int WORDS_PER_LINE = 4,
  parameter int OFF_W          = 2,
  parameter int MEM_LAT        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             dirty0,
  input  logic             dirty1,
  output logic             cache_en0,
  output logic             cache_en1,
  output logic             way_sel,
  output logic             comp,
  output logic             cache_wr,
  output logic [OFF_W-1:0] cache_offset,
  output logic             mem_addr_sel,
  output logic [OFF_W-1:0] mem_offset,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             stall,
  output logic             done,
  output logic             cache_hit,
  output logic             err
);

  // Counter spans the whole fill window: N read issues plus MEM_LAT
  // cycles of trailing cache writes.
  localparam int CNT_W = $clog2(WORDS_PER_LINE + MEM_LAT + 1);
  localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORDS_PER_LINE + MEM_LAT - 1);
  localparam logic [CNT_W-1:0] N_WORDS   = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAT       = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2,
    RETRY = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             victim_bit_q;
  logic             way_q;
  logic             wr_q;

  logic req_one;
  logic req_err;
  logic hit_w0;
  logic hit_w1;
  logic any_hit;
  logic victim;
  logic victim_dirty;
  logic fill_issue;
  logic fill_write;

  // Request decode, hit qualification and victim choice for the IDLE lookup.
  always_comb begin
    req_one      = rd ^ wr;
    req_err      = rd & wr;
    hit_w0       = hit0 & valid0;
    hit_w1       = hit1 & valid1;
    any_hit      = hit_w0 | hit_w1;
    // An invalid way is always the cheapest victim; only when both ways
    // hold data does the pseudo-random bit decide.
    if (!valid0)      victim = 1'b0;
    else if (!valid1) victim = 1'b1;
    else              victim = victim_bit_q;
    victim_dirty = victim ? (valid1 & dirty1) : (valid0 & dirty0);
    // During FILL the read issue window and the cache write window overlap
    // whenever MEM_LAT < WORDS_PER_LINE.
    fill_issue   = cnt_q < N_WORDS;
    fill_write   = cnt_q >= LAT;
  end

  // Control FSM: state, word counter, victim bit and the latched access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      victim_bit_q <= 1'b0;
      way_q        <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values; blocking here would chain updates within one edge.
      unique case (state_q)
        IDLE: begin
          if (req_one) begin
            victim_bit_q <= ~victim_bit_q;
            if (!any_hit) begin
              way_q   <= victim;
              wr_q    <= wr;
              cnt_q   <= '0;
              state_q <= victim_dirty ? WB : FILL;
            end
          end
        end
        WB: begin
          if (cnt_q == WB_LAST) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FILL: begin
          if (cnt_q == FILL_LAST) begin
            cnt_q   <= '0;
            state_q <= RETRY;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RETRY: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode from state, counter and (in IDLE) the live request.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    cache_en0    = 1'b0;
    cache_en1    = 1'b0;
    way_sel      = 1'b0;
    comp         = 1'b0;
    cache_wr     = 1'b0;
    cache_offset = '0;
    mem_addr_sel = 1'b0;
    mem_offset   = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    cache_hit    = 1'b0;
    err          = 1'b0;
    // NOTE: the IDLE outputs follow the request combinationally, so they are
    // gated by reset to stay quiet while reset is held with rd/wr asserted.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (req_err) begin
            err = 1'b1;
          end else if (req_one) begin
            comp      = 1'b1;
            cache_en0 = 1'b1;
            cache_en1 = 1'b1;
            if (any_hit) begin
              way_sel   = ~hit_w0;
              cache_wr  = wr;
              done      = 1'b1;
              cache_hit = 1'b1;
            end else begin
              stall = 1'b1;
            end
          end
        end
        WB: begin
          stall        = 1'b1;
          way_sel      = way_q;
          cache_en0    = ~way_q;
          cache_en1    = way_q;
          cache_offset = OFF_W'(cnt_q);
          mem_wr       = 1'b1;
          mem_offset   = OFF_W'(cnt_q);
          mem_addr_sel = 1'b1;
        end
        FILL: begin
          stall   = 1'b1;
          way_sel = way_q;
          if (fill_issue) begin
            mem_rd     = 1'b1;
            mem_offset = OFF_W'(cnt_q);
          end
          if (fill_write) begin
            cache_wr     = 1'b1;
            cache_en0    = ~way_q;
            cache_en1    = way_q;
            cache_offset = OFF_W'(cnt_q - LAT);
          end
        end
        RETRY: begin
          stall     = 1'b1;
          comp      = 1'b1;
          way_sel   = way_q;
          cache_en0 = ~way_q;
          cache_en1 = way_q;
          cache_wr  = wr_q;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_system_ctrl_2way.sv
// Bench for mem_system_ctrl_2way: a default instance (N=4, MEM_LAT=2) and a
// wide instance (N=8, MEM_LAT=3). A per-instance transaction-timeline model
// predicts every output on every cycle; directed transactions add literal
// latency and activity-count expectations.
module tb_mem_system_ctrl_2way;

  localparam int N_A = 4;
  localparam int L_A = 2;
  localparam int N_B = 8;
  localparam int L_B = 3;

  typedef struct packed {
    logic       en0;
    logic       en1;
    logic       way_sel;
    logic       comp;
    logic       cache_wr;
    logic [3:0] cache_offset;
    logic       mem_addr_sel;
    logic [3:0] mem_offset;
    logic       mem_rd;
    logic       mem_wr;
    logic       stall;
    logic       done;
    logic       cache_hit;
    logic       err;
  } out_t;

  typedef struct {
    bit busy;
    int k;
    bit victim;
    bit wb;
    bit wr;
    bit vbit;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic rd_v[2], wr_v[2], h0_v[2], h1_v[2], v0_v[2], v1_v[2], d0_v[2], d1_v[2];

  logic       en0_a, en1_a, ws_a, comp_a, cwr_a, mas_a, mrd_a, mwr_a;
  logic       stall_a, done_a, ch_a, err_a;
  logic [1:0] co_a, mo_a;
  logic       en0_b, en1_b, ws_b, comp_b, cwr_b, mas_b, mrd_b, mwr_b;
  logic       stall_b, done_b, ch_b, err_b;
  logic [2:0] co_b, mo_b;

  out_t o_a, o_b;
  assign o_a = {en0_a, en1_a, ws_a, comp_a, cwr_a, 2'b00, co_a, mas_a, 2'b00, mo_a,
                mrd_a, mwr_a, stall_a, done_a, ch_a, err_a};
  assign o_b = {en0_b, en1_b, ws_b, comp_b, cwr_b, 1'b0, co_b, mas_b, 1'b0, mo_b,
                mrd_b, mwr_b, stall_b, done_b, ch_b, err_b};

  mem_system_ctrl_2way #(.WORDS_PER_LINE(N_A), .OFF_W(2), .MEM_LAT(L_A)) u_dut_a (
    .clk(clk), .rst(rst), .rd(rd_v[0]), .wr(wr_v[0]),
    .hit0(h0_v[0]), .hit1(h1_v[0]), .valid0(v0_v[0]), .valid1(v1_v[0]),
    .dirty0(d0_v[0]), .dirty1(d1_v[0]),
    .cache_en0(en0_a), .cache_en1(en1_a), .way_sel(ws_a), .comp(comp_a),
    .cache_wr(cwr_a), .cache_offset(co_a), .mem_addr_sel(mas_a), .mem_offset(mo_a),
    .mem_rd(mrd_a), .mem_wr(mwr_a), .stall(stall_a), .done(done_a),
    .cache_hit(ch_a), .err(err_a)
  );

  mem_system_ctrl_2way #(.WORDS_PER_LINE(N_B), .OFF_W(3), .MEM_LAT(L_B)) u_dut_b (
    .clk(clk), .rst(rst), .rd(rd_v[1]), .wr(wr_v[1]),
    .hit0(h0_v[1]), .hit1(h1_v[1]), .valid0(v0_v[1]), .valid1(v1_v[1]),
    .dirty0(d0_v[1]), .dirty1(d1_v[1]),
    .cache_en0(en0_b), .cache_en1(en1_b), .way_sel(ws_b), .comp(comp_b),
    .cache_wr(cwr_b), .cache_offset(co_b), .mem_addr_sel(mas_b), .mem_offset(mo_b),
    .mem_rd(mrd_b), .mem_wr(mwr_b), .stall(stall_b), .done(done_b),
    .cache_hit(ch_b), .err(err_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t o_sel(input int s);
    return (s != 0) ? o_b : o_a;
  endfunction

  // Expected outputs k cycles after a missing request (k >= 1): optional
  // write-back of n words, then n+lat fill cycles, then the retry cycle.
  function automatic out_t exp_busy(input int k, input int n, input int lat,
                                    input bit v, input bit wb, input bit wr);
    out_t e;
    int   nwb;
    int   c;
    e         = '0;
    e.stall   = 1'b1;
    e.way_sel = v;
    nwb       = wb ? n : 0;
    if (k <= nwb) begin
      e.en0          = !v;
      e.en1          = v;
      e.cache_offset = 4'(k - 1);
      e.mem_wr       = 1'b1;
      e.mem_offset   = 4'(k - 1);
      e.mem_addr_sel = 1'b1;
    end else if (k <= nwb + n + lat) begin
      c = k - nwb - 1;
      if (c < n) begin
        e.mem_rd     = 1'b1;
        e.mem_offset = 4'(c);
      end
      if (c >= lat) begin
        e.cache_wr     = 1'b1;
        e.en0          = !v;
        e.en1          = v;
        e.cache_offset = 4'(c - lat);
      end
    end else begin
      e.comp     = 1'b1;
      e.en0      = !v;
      e.en1      = v;
      e.cache_wr = wr;
      e.done     = 1'b1;
    end
    return e;
  endfunction

  // One model step for instance s: expected outputs now, model state after the edge.
  task automatic model_step(input int s, input mdl_t m, output out_t e, output mdl_t mn);
    int n;
    int lat;
    bit h0w;
    bit h1w;
    n   = (s != 0) ? N_B : N_A;
    lat = (s != 0) ? L_B : L_A;
    e   = '0;
    mn  = m;
    if (!rst) begin
      mn.busy = 0; mn.k = 0; mn.victim = 0; mn.wb = 0; mn.wr = 0; mn.vbit = 0;
    end else if (m.busy) begin
      e    = exp_busy(m.k, n, lat, m.victim, m.wb, m.wr);
      mn.k = m.k + 1;
      if (m.k == (m.wb ? n : 0) + n + lat + 1) mn.busy = 0;
    end else if (rd_v[s] && wr_v[s]) begin
      e.err = 1'b1;
    end else if (rd_v[s] || wr_v[s]) begin
      e.comp = 1'b1;
      e.en0  = 1'b1;
      e.en1  = 1'b1;
      h0w    = h0_v[s] && v0_v[s];
      h1w    = h1_v[s] && v1_v[s];
      mn.vbit = !m.vbit;
      if (h0w || h1w) begin
        e.way_sel   = !h0w;
        e.cache_wr  = wr_v[s];
        e.done      = 1'b1;
        e.cache_hit = 1'b1;
      end else begin
        e.stall   = 1'b1;
        mn.busy   = 1;
        mn.k      = 1;
        mn.victim = !v0_v[s] ? 1'b0 : (!v1_v[s] ? 1'b1 : m.vbit);
        mn.wb     = mn.victim ? (v1_v[s] && d1_v[s]) : (v0_v[s] && d0_v[s]);
        mn.wr     = wr_v[s];
      end
    end
  endtask

  // Per-cycle compare of both instances against the model, mid-cycle.
  initial begin
    mdl_t mdl[2];
    mdl_t nm;
    out_t e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        model_step(s, mdl[s], e, nm);
        check((s != 0) ? "cycle_b" : "cycle_a", 32'(o_sel(s)), 32'(e));
        mdl[s] = nm;
      end
    end
  end

  task automatic set_in(input int s, input bit rd, input bit wr, input bit h0, input bit h1,
                        input bit v0, input bit v1, input bit d0, input bit d1);
    rd_v[s] = rd; wr_v[s] = wr; h0_v[s] = h0; h1_v[s] = h1;
    v0_v[s] = v0; v1_v[s] = v1; d0_v[s] = d0; d1_v[s] = d1;
  endtask

  // Issue one request (called just after a rising edge), hold it until done,
  // and report latency (inclusive), activity counts and done-cycle outputs.
  task automatic run_txn(input int s, input bit rd, input bit wr, input bit h0, input bit h1,
                         input bit v0, input bit v1, input bit d0, input bit d1,
                         output int lat, output int mrd, output int mwr, output int cwr,
                         output int first_cw, output out_t done_o);
    out_t o;
    set_in(s, rd, wr, h0, h1, v0, v1, d0, d1);
    lat = 0; mrd = 0; mwr = 0; cwr = 0; first_cw = -1; done_o = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      o = o_sel(s);
      if (o.mem_rd) mrd++;
      if (o.mem_wr) mwr++;
      if (o.cache_wr) begin
        cwr++;
        if (first_cw < 0) first_cw = cyc;
      end
      if (o.done) begin
        lat    = cyc + 1;
        done_o = o;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    set_in(s, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int   lat, mrd, mwr, cwr, fcw;
    out_t dn;
    for (int s = 0; s < 2; s++) set_in(s, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd_v[0] = 1'b1;
    #1;
    check("reset_outs_with_rd", 32'(o_a), 32'd0);
    rd_v[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Read hit in way1 only: single-cycle completion.
    run_txn(0, 1, 0, 0, 1, 0, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("hit1_latency", 32'(lat), 32'd1);
    check("hit1_way_sel", 32'(dn.way_sel), 32'd1);
    check("hit1_cache_hit", 32'(dn.cache_hit), 32'd1);
    check("hit1_stall", 32'(dn.stall), 32'd0);

    // Clean read miss into invalid way0.
    run_txn(0, 1, 0, 0, 0, 0, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("clean_miss_latency", 32'(lat), 32'd8);
    check("clean_miss_mem_rd", 32'(mrd), 32'd4);
    check("clean_miss_mem_wr", 32'(mwr), 32'd0);
    check("clean_miss_cache_wr", 32'(cwr), 32'd4);
    check("clean_miss_first_cw", 32'(fcw), 32'd3);
    check("clean_miss_hit_flag", 32'(dn.cache_hit), 32'd0);

    // Both ways hit: way0 wins.
    run_txn(0, 1, 0, 1, 1, 1, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("both_hit_latency", 32'(lat), 32'd1);
    check("both_hit_way_sel", 32'(dn.way_sel), 32'd0);

    // Write miss, both valid, victim bit now 1, way1 dirty: write-back first.
    run_txn(0, 0, 1, 0, 0, 1, 1, 0, 1, lat, mrd, mwr, cwr, fcw, dn);
    check("dirty_miss_latency", 32'(lat), 32'd12);
    check("dirty_miss_mem_wr", 32'(mwr), 32'd4);
    check("dirty_miss_mem_rd", 32'(mrd), 32'd4);
    check("dirty_miss_cache_wr", 32'(cwr), 32'd5);
    check("dirty_miss_way_sel", 32'(dn.way_sel), 32'd1);

    // Illegal rd+wr: one err pulse and nothing else.
    set_in(0, 1, 1, 0, 0, 1, 1, 1, 1);
    @(negedge clk);
    check("err_pulse", 32'(o_a), 32'h1);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("err_cleared", 32'(o_a), 32'd0);
    @(posedge clk);
    #1;

    // Miss with way1 invalid: way1 is victim, way0 dirtiness irrelevant.
    run_txn(0, 1, 0, 0, 0, 1, 0, 1, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("inv1_miss_latency", 32'(lat), 32'd8);
    check("inv1_miss_mem_wr", 32'(mwr), 32'd0);
    check("inv1_miss_way_sel", 32'(dn.way_sel), 32'd1);

    // hit0 without valid0 is not a hit; way1 hit wins.
    run_txn(0, 1, 0, 1, 1, 0, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("unqual_hit0_latency", 32'(lat), 32'd1);
    check("unqual_hit0_way_sel", 32'(dn.way_sel), 32'd1);

    // Write miss, both valid, victim bit 0: way0 clean victim, dirty1 ignored.
    run_txn(0, 0, 1, 0, 0, 1, 1, 0, 1, lat, mrd, mwr, cwr, fcw, dn);
    check("vb0_miss_latency", 32'(lat), 32'd8);
    check("vb0_miss_way_sel", 32'(dn.way_sel), 32'd0);
    check("vb0_miss_cache_wr", 32'(cwr), 32'd5);

    // Asynchronous reset in the middle of FILL at counter 3.
    set_in(0, 1, 0, 0, 0, 0, 1, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_mem_rd", 32'(o_a.mem_rd), 32'd1);
    check("pre_rst_mem_offset", 32'(o_a.mem_offset), 32'd3);
    rst = 1'b0;
    #1;
    check("async_rst_outs", 32'(o_a), 32'd0);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_txn(0, 1, 0, 1, 0, 1, 0, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("post_rst_hit_latency", 32'(lat), 32'd1);
    // Victim bit restarts at 0 after reset and toggled once: next clean miss goes to way1.
    run_txn(0, 1, 0, 0, 0, 1, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("post_rst_miss_way_sel", 32'(dn.way_sel), 32'd1);

    // Wide instance: 8 words, latency 3, clean miss.
    run_txn(1, 1, 0, 0, 0, 0, 1, 0, 0, lat, mrd, mwr, cwr, fcw, dn);
    check("wide_miss_latency", 32'(lat), 32'd13);
    check("wide_miss_mem_rd", 32'(mrd), 32'd8);
    check("wide_miss_cache_wr", 32'(cwr), 32'd8);
    check("wide_miss_first_cw", 32'(fcw), 32'd4);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
